// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: RAW hazard detector beside the ID stage.
// Tracks DEPTH in-flight producers in a shift buffer (slot 0 = EX, slot DEPTH-1 = oldest).
// It compares the ID source registers against that buffer. From the result it drives
// stall, the remaining stall count and the per-operand bypass selects.
// Optional feature macro: FORWARDING_EN. When it is defined, only a load-use hazard
// stalls; every other hazard is resolved by bypass. When it is undefined, every RAW
// hazard stalls and the bypass selects are tied to 0.
module hazard_scoreboard_unit #(
  parameter int unsigned REGISTERWIDTH = 5,
  parameter int unsigned DEPTH         = 3,
  parameter int unsigned CNTWIDTH      = 16,
  localparam int unsigned SW           = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REGISTERWIDTH-1:0] id_rs1,
  input  logic                     id_rs1_used,
  input  logic [REGISTERWIDTH-1:0] id_rs2,
  input  logic                     id_rs2_used,
  input  logic                     id_wr_en,
  input  logic [REGISTERWIDTH-1:0] id_rd,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic [SW-1:0]            stall_cycles,
  output logic [SW-1:0]            fwd_sel_rs1,
  output logic [SW-1:0]            fwd_sel_rs2,
  output logic [CNTWIDTH-1:0]      stall_count
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         wr_en_q, wr_en_d;
  logic [REGISTERWIDTH-1:0] rd_q [DEPTH];
  logic [REGISTERWIDTH-1:0] rd_d [DEPTH];
`ifdef FORWARDING_EN
  logic [DEPTH-1:0]         is_load_q, is_load_d;
`else
  logic                     unused_is_load;
`endif
  logic [CNTWIDTH-1:0]      stall_count_q, stall_count_d;

  logic [DEPTH-1:0] live_c;
  logic             rs1_hit_c, rs2_hit_c;
  logic [SW-1:0]    rs1_k_c, rs2_k_c;

  // Youngest live producer matching each operand (r0 is never a hazard)
  always_comb begin
    live_c    = '0;
    rs1_hit_c = 1'b0;
    rs2_hit_c = 1'b0;
    rs1_k_c   = '0;
    rs2_k_c   = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      live_c[k] = valid_q[k] && wr_en_q[k] && (rd_q[k] != '0);
      if (id_valid && id_rs1_used && live_c[k] && (rd_q[k] == id_rs1)) begin
        rs1_hit_c = 1'b1;
        rs1_k_c   = SW'(k);
      end
      if (id_valid && id_rs2_used && live_c[k] && (rd_q[k] == id_rs2)) begin
        rs2_hit_c = 1'b1;
        rs2_k_c   = SW'(k);
      end
    end
  end

`ifdef FORWARDING_EN
  // Stall only when a load sits in slot 0; otherwise bypass from the youngest match
  always_comb begin
    stall        = 1'b0;
    stall_cycles = '0;
    fwd_sel_rs1  = '0;
    fwd_sel_rs2  = '0;
    if ((rs1_hit_c && (rs1_k_c == '0) && is_load_q[0]) ||
        (rs2_hit_c && (rs2_k_c == '0) && is_load_q[0])) begin
      stall        = 1'b1;
      stall_cycles = SW'(1);
    end else begin
      if (rs1_hit_c) fwd_sel_rs1 = rs1_k_c + SW'(1);
      if (rs2_hit_c) fwd_sel_rs2 = rs2_k_c + SW'(1);
    end
  end
`else
  logic [SW-1:0] kmin_c;

  // Stall on any match until the youngest matching producer leaves the buffer
  always_comb begin
    stall        = 1'b0;
    stall_cycles = '0;
    fwd_sel_rs1  = '0;
    fwd_sel_rs2  = '0;
    kmin_c       = '0;
    if (rs1_hit_c && rs2_hit_c) kmin_c = (rs1_k_c < rs2_k_c) ? rs1_k_c : rs2_k_c;
    else if (rs1_hit_c)         kmin_c = rs1_k_c;
    else                        kmin_c = rs2_k_c;
    if (rs1_hit_c || rs2_hit_c) begin
      stall        = 1'b1;
      stall_cycles = SW'(DEPTH) - kmin_c;
    end
  end

  // The load flag only matters when bypassing is built in
  assign unused_is_load = id_is_load;
`endif

  // Shift the buffer each cycle; slot 0 takes the issuing instruction or a bubble
  always_comb begin
    valid_d    = '0;
    wr_en_d    = '0;
    for (int k = 0; k < int'(DEPTH); k++) rd_d[k] = '0;
`ifdef FORWARDING_EN
    is_load_d    = '0;
    is_load_d[0] = id_is_load;
`endif
    valid_d[0] = id_valid && !stall && !flush;
    wr_en_d[0] = id_wr_en;
    rd_d[0]    = id_rd;
    for (int k = 1; k < int'(DEPTH); k++) begin
      valid_d[k] = valid_q[k-1] && !flush;
      wr_en_d[k] = wr_en_q[k-1];
      rd_d[k]    = rd_q[k-1];
`ifdef FORWARDING_EN
      is_load_d[k] = is_load_q[k-1];
`endif
    end
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + CNTWIDTH'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      wr_en_q       <= '0;
      for (int k = 0; k < int'(DEPTH); k++) rd_q[k] <= '0;
`ifdef FORWARDING_EN
      is_load_q     <= '0;
`endif
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      wr_en_q       <= wr_en_d;
      for (int k = 0; k < int'(DEPTH); k++) rd_q[k] <= rd_d[k];
`ifdef FORWARDING_EN
      is_load_q     <= is_load_d;
`endif
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
